// File: rtl/mpu_frame_collector.sv
// Paces MPU-6050 burst reads and assembles the 14 streamed bytes into seven signed words.
// Build option MPU_OFFSET_EN: subtract a saturating gyro bias from gyro_x/y/z at publish time.
module mpu_frame_collector #(
  parameter int                 SAMPLE_DIV   = 50000,
  parameter int                 BYTE_TIMEOUT = 20000,
  parameter logic signed [15:0] GYRO_X_OFS   = 16'sh0000,
  parameter logic signed [15:0] GYRO_Y_OFS   = 16'sh0000,
  parameter logic signed [15:0] GYRO_Z_OFS   = 16'sh0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        init_done,
  input  logic        busy_now,
  input  logic        data_avalid,
  input  logic [7:0]  data,
  output logic        mpu_transfer,
  output logic [15:0] accel_x,
  output logic [15:0] accel_y,
  output logic [15:0] accel_z,
  output logic [15:0] temp,
  output logic [15:0] gyro_x,
  output logic [15:0] gyro_y,
  output logic [15:0] gyro_z,
  output logic        frame_valid,
  output logic        frame_err,
  output logic        frame_overrun,
  output logic [15:0] frame_cnt
);

  localparam int TW = $clog2(BYTE_TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_TICK,
    S_REQ,
    S_COLLECT,
    S_PUBLISH
  } state_t;

  state_t        r_state;
  logic [23:0]   r_tick_cnt;
  logic [TW-1:0] r_to_cnt;
  logic [3:0]    r_idx;
  logic [7:0]    r_shadow [0:12];
  logic [15:0]   r_word [0:6];
  logic          r_frame_valid;
  logic          r_frame_err;
  logic          r_frame_overrun;
  logic [15:0]   r_frame_cnt;

  logic          w_run;
  logic          w_tick;
  logic          w_to_hit;
  logic          w_store;
  logic          w_last;
  logic [7:0]    w_byte [0:13];
  logic [15:0]   w_raw [0:6];
  logic [15:0]   w_pub [0:6];

  assign w_run    = enable && init_done;
  assign w_tick   = w_run && (r_tick_cnt == 24'(SAMPLE_DIV - 1));
  assign w_to_hit = (r_to_cnt == TW'(BYTE_TIMEOUT - 1));
  assign w_store  = w_run && (r_state == S_COLLECT) && data_avalid;
  assign w_last   = w_store && (r_idx == 4'd13);

  always_ff @(posedge clk) begin
    if (rst || !w_run) begin
      r_tick_cnt <= '0;
    end else if (w_tick) begin
      r_tick_cnt <= '0;
    end else begin
      r_tick_cnt <= r_tick_cnt + 24'd1;
    end
  end

  // The 14th byte is never parked: it feeds the output words straight from the bus,
  // so the words and frame_valid appear the cycle after it is sampled.
  genvar gi;
  generate
    for (gi = 0; gi < 13; gi++) begin : g_shadow
      always_ff @(posedge clk) begin
        if (rst) begin
          r_shadow[gi] <= '0;
        end else if (w_store && (r_idx == 4'(gi))) begin
          r_shadow[gi] <= data;
        end
      end
      assign w_byte[gi] = r_shadow[gi];
    end
  endgenerate
  assign w_byte[13] = data;

  generate
    for (gi = 0; gi < 7; gi++) begin : g_word
      assign w_raw[gi] = {w_byte[2*gi], w_byte[2*gi+1]};
      if (gi >= 4) begin : g_gyro
`ifdef MPU_OFFSET_EN
        localparam logic signed [15:0] OFS = (gi == 4) ? GYRO_X_OFS :
                                             (gi == 5) ? GYRO_Y_OFS : GYRO_Z_OFS;
        logic [16:0] w_diff;
        assign w_diff    = {w_raw[gi][15], w_raw[gi]} - {OFS[15], OFS};
        // Bits 16 and 15 disagree only when the 17-bit result left the 16-bit range.
        assign w_pub[gi] = (w_diff[16] != w_diff[15]) ? {w_diff[16], {15{~w_diff[16]}}}
                                                      : w_diff[15:0];
`else
        assign w_pub[gi] = w_raw[gi];
`endif
      end else begin : g_plain
        assign w_pub[gi] = w_raw[gi];
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          r_word[gi] <= '0;
        end else if (w_last) begin
          r_word[gi] <= w_pub[gi];
        end
      end
    end
  endgenerate

`ifndef MPU_OFFSET_EN
  logic [47:0] w_unused_ofs;
  assign w_unused_ofs = {GYRO_X_OFS, GYRO_Y_OFS, GYRO_Z_OFS};
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state         <= S_IDLE;
      r_to_cnt        <= '0;
      r_idx           <= '0;
      r_frame_valid   <= 1'b0;
      r_frame_err     <= 1'b0;
      r_frame_overrun <= 1'b0;
      r_frame_cnt     <= '0;
    end else begin
      r_frame_valid   <= 1'b0;
      r_frame_err     <= 1'b0;
      r_frame_overrun <= 1'b0;
      if (!w_run) begin
        r_state <= S_IDLE;
      end else begin
        if (w_tick && (r_state == S_REQ || r_state == S_COLLECT || r_state == S_PUBLISH)) begin
          r_frame_overrun <= 1'b1;
        end
        case (r_state)
          S_IDLE: r_state <= S_WAIT_TICK;
          S_WAIT_TICK: begin
            if (w_tick) begin
              r_state  <= S_REQ;
              r_to_cnt <= '0;
            end
          end
          S_REQ: begin
            if (!busy_now) begin
              r_idx    <= '0;
              r_to_cnt <= '0;
              r_state  <= S_COLLECT;
            end else if (w_to_hit) begin
              r_frame_err <= 1'b1;
              r_state     <= S_WAIT_TICK;
            end else begin
              r_to_cnt <= r_to_cnt + TW'(1);
            end
          end
          S_COLLECT: begin
            if (data_avalid) begin
              r_to_cnt <= '0;
              r_idx    <= r_idx + 4'd1;
              if (w_last) begin
                r_frame_valid <= 1'b1;
                r_frame_cnt   <= r_frame_cnt + 16'd1;
                r_state       <= S_PUBLISH;
              end
            end else if (w_to_hit) begin
              r_frame_err <= 1'b1;
              r_state     <= S_WAIT_TICK;
            end else begin
              r_to_cnt <= r_to_cnt + TW'(1);
            end
          end
          S_PUBLISH: r_state <= S_WAIT_TICK;
          default:   r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign mpu_transfer  = !rst && w_run && (r_state == S_REQ) && !busy_now;
  assign accel_x       = r_word[0];
  assign accel_y       = r_word[1];
  assign accel_z       = r_word[2];
  assign temp          = r_word[3];
  assign gyro_x        = r_word[4];
  assign gyro_y        = r_word[5];
  assign gyro_z        = r_word[6];
  assign frame_valid   = r_frame_valid;
  assign frame_err     = r_frame_err;
  assign frame_overrun = r_frame_overrun;
  assign frame_cnt     = r_frame_cnt;

endmodule

// File: tb/tb_mpu_frame_collector.sv
// Directed + randomized bench for mpu_frame_collector with a frame-level reference model.
module tb_mpu_frame_collector;
  localparam int DIV = 200;
  localparam int TO  = 100;
  localparam logic signed [15:0] OFS_X = 16'sh0010;
  localparam logic signed [15:0] OFS_Y = -16'sd3;
  localparam logic signed [15:0] OFS_Z = 16'sh7FFF;
`ifdef MPU_OFFSET_EN
  localparam bit OFS_EN = 1'b1;
`else
  localparam bit OFS_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst, enable, init_done, busy_now, data_avalid;
  logic [7:0] data;
  logic mpu_transfer, frame_valid, frame_err, frame_overrun;
  logic [15:0] accel_x, accel_y, accel_z, temp, gyro_x, gyro_y, gyro_z, frame_cnt;

  mpu_frame_collector #(
    .SAMPLE_DIV(DIV), .BYTE_TIMEOUT(TO),
    .GYRO_X_OFS(OFS_X), .GYRO_Y_OFS(OFS_Y), .GYRO_Z_OFS(OFS_Z)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .init_done(init_done), .busy_now(busy_now),
    .data_avalid(data_avalid), .data(data), .mpu_transfer(mpu_transfer),
    .accel_x(accel_x), .accel_y(accel_y), .accel_z(accel_z), .temp(temp),
    .gyro_x(gyro_x), .gyro_y(gyro_y), .gyro_z(gyro_z),
    .frame_valid(frame_valid), .frame_err(frame_err), .frame_overrun(frame_overrun),
    .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int xfer_bad = 0;
  int ovr_q[$];
  int t0, p, s, w, k, n_ovr;
  logic [7:0]  fb [14];
  logic [15:0] m_w [7];
  int m_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One cycle: outputs are sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (mpu_transfer && busy_now) xfer_bad++;
    if (frame_overrun) ovr_q.push_back(cyc);
  endtask

  function automatic logic [15:0] exp_gyro(input logic [15:0] raw, input logic signed [15:0] ofs);
    int d;
    logic [15:0] sat;
    d = int'($signed(raw)) - int'(ofs);
    if (d > 32767) sat = 16'h7FFF;
    else if (d < -32768) sat = 16'h8000;
    else sat = d[15:0];
    return OFS_EN ? sat : raw;
  endfunction

  // Reference: word k is bytes 2k (high) and 2k+1 (low); gyro words carry the optional bias.
  task automatic model_frame();
    for (int i = 0; i < 7; i++) m_w[i] = {fb[2*i], fb[2*i+1]};
    m_w[4] = exp_gyro(m_w[4], OFS_X);
    m_w[5] = exp_gyro(m_w[5], OFS_Y);
    m_w[6] = exp_gyro(m_w[6], OFS_Z);
    m_cnt++;
  endtask

  function automatic int next_slot(input int c);
    if (c <= t0) return t0;
    return t0 + ((c - t0 + DIV - 1) / DIV) * DIV;
  endfunction

  task automatic check_words(input string tag);
    chk({tag, "_accel_x"}, 32'(accel_x), 32'(m_w[0]));
    chk({tag, "_accel_y"}, 32'(accel_y), 32'(m_w[1]));
    chk({tag, "_accel_z"}, 32'(accel_z), 32'(m_w[2]));
    chk({tag, "_temp"},    32'(temp),    32'(m_w[3]));
    chk({tag, "_gyro_x"},  32'(gyro_x),  32'(m_w[4]));
    chk({tag, "_gyro_y"},  32'(gyro_y),  32'(m_w[5]));
    chk({tag, "_gyro_z"},  32'(gyro_z),  32'(m_w[6]));
    chk({tag, "_cnt"},     32'(frame_cnt), 32'(m_cnt));
  endtask

  task automatic wait_xfer(input string tag, input int exp_cyc);
    int n = 0;
    while (!mpu_transfer && n < 3 * DIV) begin
      step();
      n++;
    end
    chk({tag, "_seen"}, 32'(mpu_transfer), 32'd1);
    chk({tag, "_cycle"}, 32'(cyc), 32'(exp_cyc));
  endtask

  task automatic send_bytes(input int nb, input int gmin, input int gmax);
    for (int i = 0; i < nb; i++) begin
      data = fb[i];
      data_avalid = 1'b1;
      step();
      data_avalid = 1'b0;
      if (i < 13) chk("no_early_valid", 32'(frame_valid), 32'd0);
      if (i < nb - 1) repeat ($urandom_range(gmax, gmin)) step();
    end
  endtask

  task automatic finish_frame(input string tag);
    model_frame();
    chk({tag, "_valid"}, 32'(frame_valid), 32'd1);
    check_words(tag);
    $display("frame %s: cnt=%0d ax=%h temp=%h gx=%h gz=%h", tag, frame_cnt, accel_x, temp, gyro_x, gyro_z);
    p = cyc;
    step();
    chk({tag, "_valid_drop"}, 32'(frame_valid), 32'd0);
    chk({tag, "_hold"}, 32'(accel_x), 32'(m_w[0]));
  endtask

  task automatic rand_frame();
    for (int i = 0; i < 14; i++) fb[i] = 8'($urandom);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; enable = 1'b0; init_done = 1'b0; busy_now = 1'b0; data_avalid = 1'b0; data = 8'h00;
    m_cnt = 0;
    for (int i = 0; i < 7; i++) m_w[i] = 16'h0;
    repeat (3) step();
    rst = 1'b0;
    step();
    check_words("reset");
    chk("reset_valid", 32'(frame_valid), 32'd0);
    chk("reset_err", 32'(frame_err), 32'd0);
    chk("reset_ovr", 32'(frame_overrun), 32'd0);
    chk("reset_xfer", 32'(mpu_transfer), 32'd0);

    // First request DIV cycles after counting starts.
    enable = 1'b1; init_done = 1'b1;
    t0 = cyc + DIV;
    wait_xfer("first_xfer", t0);
    check_words("pre_frame");
    step();
    chk("xfer_pulse_width", 32'(mpu_transfer), 32'd0);
    for (int i = 0; i < 14; i++) fb[i] = 8'(i + 1);
    send_bytes(14, 0, 2);
    finish_frame("directed");

    // Random frames, two of them carrying the gyro_x saturation/offset corner values.
    for (int f = 0; f < 4; f++) begin
      data = 8'($urandom); data_avalid = 1'b1;
      step();
      data_avalid = 1'b0;
      wait_xfer("rand_xfer", next_slot(p + 2));
      step();
      rand_frame();
      if (f == 1) begin fb[8] = 8'h80; fb[9] = 8'h05; end
      if (f == 2) begin fb[8] = 8'h01; fb[9] = 8'h00; end
      send_bytes(14, 0, 3);
      finish_frame("random");
    end

    // busy_now high across the tick and for 30 cycles of REQ.
    busy_now = 1'b1;
    s = next_slot(p + 2);
    while (cyc < s + 30) step();
    chk("xfer_while_busy", 32'(mpu_transfer), 32'd0);
    busy_now = 1'b0;
    #1;
    chk("xfer_after_busy", 32'(mpu_transfer), 32'd1);
    step();
    rand_frame();
    send_bytes(14, 0, 2);
    finish_frame("busy");
    chk("no_xfer_while_busy", 32'(xfer_bad), 32'd0);

    // Partial frame: 5 bytes then silence.
    wait_xfer("to_xfer", next_slot(p + 2));
    step();
    rand_frame();
    send_bytes(5, 0, 2);
    k = 0;
    while (!frame_err && k < TO + 50) begin
      step();
      k++;
    end
    chk("timeout_delay", 32'(k), 32'(TO));
    chk("timeout_no_valid", 32'(frame_valid), 32'd0);
    check_words("timeout_hold");
    $display("timeout: err after %0d cycles", k);
    w = cyc;
    step();
    chk("err_pulse_width", 32'(frame_err), 32'd0);
    wait_xfer("after_to_xfer", next_slot(w + 1));
    step();
    rand_frame();
    send_bytes(14, 0, 2);
    finish_frame("after_timeout");

    // Slow frame straddles a tick.
    n_ovr = ovr_q.size();
    wait_xfer("slow_xfer", next_slot(p + 2));
    s = cyc;
    step();
    rand_frame();
    send_bytes(14, 16, 16);
    finish_frame("slow");
    chk("overrun_count", 32'(ovr_q.size()), 32'(n_ovr + 1));
    if (ovr_q.size() > 0) chk("overrun_cycle", 32'(ovr_q[$]), 32'(s + DIV));
    wait_xfer("post_ovr_xfer", next_slot(p + 2));
    chk("post_ovr_slot", 32'(cyc), 32'(s + 2 * DIV));

    // enable dropped mid-frame: nothing published, schedule restarts.
    step();
    rand_frame();
    send_bytes(4, 0, 1);
    enable = 1'b0;
    k = 0;
    repeat (10) begin
      step();
      if (frame_valid || frame_err || mpu_transfer) k++;
    end
    chk("disable_quiet", 32'(k), 32'd0);
    check_words("disable_hold");
    enable = 1'b1;
    t0 = cyc + DIV;
    wait_xfer("reenable_xfer", t0);
    step();
    rand_frame();
    send_bytes(14, 0, 2);
    finish_frame("reenable");

    // Reset mid-COLLECT clears everything.
    wait_xfer("rst_xfer", next_slot(p + 2));
    step();
    rand_frame();
    send_bytes(6, 0, 1);
    rst = 1'b1;
    step();
    m_cnt = 0;
    for (int i = 0; i < 7; i++) m_w[i] = 16'h0;
    check_words("midrst");
    chk("midrst_valid", 32'(frame_valid), 32'd0);
    rst = 1'b0;
    t0 = cyc + DIV;
    wait_xfer("post_rst_xfer", t0);
    step();
    rand_frame();
    send_bytes(14, 0, 2);
    finish_frame("post_rst");
    chk("total_overruns", 32'(ovr_q.size()), 32'd1);
    chk("final_no_busy_xfer", 32'(xfer_bad), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/mpu_frame_collector.md
Name: mpu_frame_collector

Overview:
- Sits directly downstream of the MPU-6050 I2C master (`mpu`).
- Paces burst reads by pulsing `mpu_transfer` at a fixed sample rate.
- Collects the 14 bytes (0x3B..0x48) that the master streams out on `data`/`data_avalid`.
- Publishes seven signed 16-bit sensor words with a one-cycle `frame_valid` strobe to the attitude-estimation logic.

Parameters:
- SAMPLE_DIV, 50000: clock cycles between read requests (1 kHz at 50 MHz); legal range 16..2^24-1.
- BYTE_TIMEOUT, 20000: maximum cycles allowed between a request or byte and the next byte before the frame is aborted.
- GYRO_X_OFS / GYRO_Y_OFS / GYRO_Z_OFS, 0: signed 16-bit bias values; used only with MPU_OFFSET_EN.

Ports:
- clk  in  1  system clock, 50 MHz
- rst  in  1  reset, synchronous, active-high
- enable  in  1  allows sampling
- init_done  in  1  from `mpu`; sensor configured
- busy_now  in  1  from `mpu`; I2C transaction in progress
- data_avalid  in  1  from `mpu`; one-cycle strobe, `data` valid
- data  in  8  from `mpu`; read byte, MSB-first register order
- mpu_transfer  out  1  to `mpu`; one-cycle read request
- accel_x, accel_y, accel_z  out  16  signed accelerometer words
- temp  out  16  signed raw temperature word
- gyro_x, gyro_y, gyro_z  out  16  signed gyro words
- frame_valid  out  1  one-cycle strobe; all seven words updated this cycle
- frame_err  out  1  one-cycle strobe; frame aborted on timeout
- frame_overrun  out  1  one-cycle strobe; sample tick arrived while a frame was in flight
- frame_cnt  out  16  count of published frames, wraps 65535 -> 0

Behaviour:
- Reset (rst=1 at a clk edge):
  - All outputs go to 0; FSM goes to IDLE.
  - Tick counter, byte index and timeout counter clear.
  - Shadow byte registers clear.
  - Applies in any state, including mid-frame.
- Tick counter:
  - Runs only while enable && init_done; otherwise held at 0.
  - Counts 0..SAMPLE_DIV-1; generates an internal tick on the cycle it wraps to 0.
- FSM states: IDLE, WAIT_TICK, REQ, COLLECT, PUBLISH.
  - IDLE -> WAIT_TICK when enable && init_done.
  - WAIT_TICK -> REQ on tick.
  - REQ:
    - If busy_now=0: drive mpu_transfer=1 for exactly this cycle; clear byte index and timeout counter; go to COLLECT.
    - If busy_now=1: stay in REQ with mpu_transfer=0.
  - COLLECT:
    - On data_avalid=1: store `data` at shadow[byte index], increment index, clear timeout counter.
    - After index 13 is stored, go to PUBLISH.
  - PUBLISH (exactly one cycle):
    - Load outputs from the shadow registers: word k = {shadow[2k], shadow[2k+1]}. Order is accel_x, accel_y, accel_z, temp, gyro_x, gyro_y, gyro_z.
    - Assert frame_valid=1 and increment frame_cnt.
    - Go to WAIT_TICK.
- Latency: frame_valid is high on the clk edge immediately after the edge that sampled the 14th data_avalid.
- Output words hold their value between frames.
- Timeout: in REQ or COLLECT, the timeout counter increments every cycle. When it reaches BYTE_TIMEOUT:
  - Assert frame_err for one cycle.
  - Discard the partial frame; outputs and frame_cnt are unchanged.
  - Go to WAIT_TICK.
- data_avalid outside COLLECT is ignored.
- A tick in REQ, COLLECT or PUBLISH pulses frame_overrun for one cycle and is otherwise dropped; it is not queued.
- enable=0 or init_done=0 in any non-IDLE state:
  - Go to IDLE on the next edge; a partial frame is discarded.
  - No frame_valid or frame_err is generated.
  - The cycle's mpu_transfer is suppressed.
- A tick and a timeout in the same cycle: frame_err and frame_overrun both pulse; the FSM goes to WAIT_TICK and the tick is dropped.

Optional Feature:
- Macro: MPU_OFFSET_EN.
- Defined: in PUBLISH, gyro_x/y/z = raw - GYRO_*_OFS.
  - Computed in 17-bit signed arithmetic, saturated to [-32768, 32767].
  - Latency is unchanged.
  - accel and temp are unaffected.
- Undefined: gyro words are the raw bytes; GYRO_*_OFS parameters are unused and no subtractor logic exists.

Test Plan:
- rst pulse, then enable=1, init_done=1, SAMPLE_DIV=200: mpu_transfer is a single-cycle pulse 200 cycles after counting starts and every 200 cycles thereafter; all outputs are 0 before the first frame.
- After a request, model returns bytes 0x01..0x0E on 14 data_avalid strobes: frame_valid one cycle after the last strobe; accel_x=0x0102, temp=0x0708, gyro_z=0x0D0E; frame_cnt=1.
- busy_now held high for 30 cycles when the tick arrives: mpu_transfer asserts on the first cycle busy_now=0, never while busy.
- Model sends only 5 bytes, BYTE_TIMEOUT=100: frame_err pulses 100 cycles after the 5th byte; outputs and frame_cnt are unchanged; the next frame completes normally.
- Model stalls frame delivery beyond SAMPLE_DIV: frame_overrun pulses at the tick; the following request happens on the next tick after PUBLISH; rst asserted mid-COLLECT clears all outputs to 0.
- MPU_OFFSET_EN, GYRO_X_OFS=16'sh0010, raw gyro_x=0x8005: gyro_x saturates to 0x8000; with raw 0x0100, gyro_x=0x00F0.
